// File: rtl/seg7_pkg.sv
// Shared seven-segment glyphs and counter sizing helper.
// Patterns are {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic int cnt_width(int m);
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/mod_counter_if.sv
// Control and display bundle of one counter stage.
// Board/cascade logic is master, the counter is slave.
interface mod_counter_if
    import seg7_pkg::*;
#(
    parameter int MODULO = 10
);

    localparam int WIDTH  = cnt_width(MODULO);
    localparam int DIGITS = (WIDTH + 3) / 4;

    logic                  en;
    logic                  up;
    logic                  load;
    logic [WIDTH-1:0]      din;
    logic [WIDTH-1:0]      count;
    logic                  tc;
    logic [7*DIGITS-1:0]   out;

    modport master (
        output en, up, load, din,
        input  count, tc, out
    );

    modport slave (
        input  en, up, load, din,
        output count, tc, out
    );

endinterface

// File: rtl/seg7_hex.sv
// One hex digit to an active-low seven-segment glyph.
// Covers the full 0-F range.
module seg7_hex
    import seg7_pkg::*;
(
    input  logic [3:0] val,
    output logic [6:0] seg
);

    // Glyph lookup
    always_comb begin
        seg = SEG_BLANK;
        unique case (val)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/mod_counter.sv
// Modulo-N up/down counter with load, cascade carry
// and per-digit seven-segment decode.
module mod_counter
    import seg7_pkg::*;
#(
    parameter int MODULO = 10
) (
    input  logic         clk,
    input  logic         rst,
    mod_counter_if.slave bus
);

    localparam int WIDTH  = cnt_width(MODULO);
    localparam int DIGITS = (WIDTH + 3) / 4;
    localparam int PADW   = 4 * DIGITS;

    localparam logic [WIDTH-1:0] MAX =
        WIDTH'(MODULO - 1);
    localparam logic [WIDTH:0] MOD_X =
        (WIDTH + 1)'(MODULO);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [PADW-1:0]  cnt_pad;
    logic [6:0]       seg [DIGITS];
    logic             at_edge;

    // Next count: load first, then a wrap-aware step.
    // Boundaries are compared before stepping so
    // nothing ever needs more than WIDTH bits.
    always_comb begin
        count_d = count_q;
        if (bus.load) begin
            if ({1'b0, bus.din} < MOD_X)
                count_d = bus.din;
            else
                count_d = '0;
        end else if (bus.en) begin
            if (bus.up)
                count_d = (count_q == MAX) ?
                    '0 : count_q + WIDTH'(1);
            else
                count_d = (count_q == '0) ?
                    MAX : count_q - WIDTH'(1);
        end
    end

    // Count register, cleared immediately on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    // Carry out: the step about to wrap this stage
    always_comb begin
        at_edge = bus.up ? (count_q == MAX)
                         : (count_q == '0);
        bus.tc  = rst & bus.en & ~bus.load & at_edge;
    end

    assign bus.count = count_q;
    assign cnt_pad   = PADW'(count_q);

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        seg7_hex u_hex (
            .val (cnt_pad[4*k +: 4]),
            .seg (seg[k])
        );
    end

    // Pack the digit glyphs onto the display bus
    always_comb begin
        bus.out = '0;
        for (int k = 0; k < DIGITS; k++)
            bus.out[7*k +: 7] = seg[k];
    end

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench: four counter sizes share one stimulus,
// plus a two-stage decade cascade.
module tb_mod_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        up = 1'b1;
    logic        load = 1'b0;
    logic [15:0] din_raw = '0;
    bit          run = 1'b1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct {
        int cnt;
        bit tc;
    } exp_t;

    function automatic logic [6:0] glyph(int v);
        logic [3:0] n;
        n = 4'(v);
        return GLYPH[n];
    endfunction

    function automatic logic [27:0] seg_of(int c, int d);
        logic [27:0] r;
        r = '0;
        for (int k = 0; k < d; k++)
            r[7*k +: 7] = glyph(c >> (4 * k));
        return r;
    endfunction

    localparam int NM = 4;
    localparam int MODS [NM] = '{10, 5, 16, 300};

    for (genvar g = 0; g < NM; g++) begin : g_dut
        localparam int M = MODS[g];
        localparam int W =
            ($clog2(M) < 1) ? 1 : $clog2(M);
        localparam int D = (W + 3) / 4;

        mod_counter_if #(.MODULO(M)) bus ();

        mod_counter #(.MODULO(M)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        assign bus.en   = en;
        assign bus.up   = up;
        assign bus.load = load;
        assign bus.din  = din_raw[W-1:0];

        exp_t q [$];
        int   model = 0;

        // Reference model: push what the DUT should show
        // this cycle, then advance to the next edge.
        always @(posedge clk) begin : prod
            int   dv;
            exp_t e;
            #3;
            if (run) begin
                dv = int'(din_raw[W-1:0]);
                if (!rst) model = 0;
                e.cnt = model;
                e.tc  = rst && en && !load &&
                        (up ? model == M - 1
                            : model == 0);
                q.push_back(e);
                if (rst) begin
                    if (load)
                        model = (dv < M) ? dv : 0;
                    else if (en && up)
                        model = (model + 1) % M;
                    else if (en)
                        model = (model + M - 1) % M;
                end
            end
        end

        // Monitor: compare DUT outputs mid-cycle
        always @(negedge clk) begin : mon
            exp_t        e;
            logic [27:0] xo;
            if (q.size() != 0) begin
                e  = q.pop_front();
                xo = seg_of(e.cnt, D);
                checks++;
                if (int'(bus.count) != e.cnt) begin
                    failures++;
                    $display(
                      "FAIL m%0d count t=%0t got=%0d exp=%0d",
                      M, $time, bus.count, e.cnt);
                end
                checks++;
                if (bus.tc != e.tc) begin
                    failures++;
                    $display(
                      "FAIL m%0d tc t=%0t got=%0b exp=%0b",
                      M, $time, bus.tc, e.tc);
                end
                checks++;
                if (28'(bus.out) != xo) begin
                    failures++;
                    $display(
                      "FAIL m%0d out t=%0t got=%h exp=%h",
                      M, $time, bus.out, xo);
                end
            end
        end
    end

    mod_counter_if #(.MODULO(10)) lo_bus ();
    mod_counter_if #(.MODULO(10)) hi_bus ();

    mod_counter #(.MODULO(10)) u_lo (
        .clk (clk),
        .rst (rst),
        .bus (lo_bus)
    );

    mod_counter #(.MODULO(10)) u_hi (
        .clk (clk),
        .rst (rst),
        .bus (hi_bus)
    );

    assign lo_bus.en   = 1'b1;
    assign lo_bus.up   = 1'b1;
    assign lo_bus.load = 1'b0;
    assign lo_bus.din  = '0;
    assign hi_bus.en   = lo_bus.tc;
    assign hi_bus.up   = 1'b1;
    assign hi_bus.load = 1'b0;
    assign hi_bus.din  = '0;

    int cq [$];
    int cval = 0;

    // Cascade model: a free-running two-digit decimal value
    always @(posedge clk) begin
        #3;
        if (run) begin
            if (!rst) cval = 0;
            cq.push_back(cval);
            if (rst) cval = (cval + 1) % 100;
        end
    end

    // Cascade monitor
    always @(negedge clk) begin : cmon
        int v;
        if (cq.size() != 0) begin
            v = cq.pop_front();
            checks++;
            if (int'(lo_bus.count) != v % 10) begin
                failures++;
                $display(
                  "FAIL casc_lo t=%0t got=%0d exp=%0d",
                  $time, lo_bus.count, v % 10);
            end
            checks++;
            if (int'(hi_bus.count) != v / 10) begin
                failures++;
                $display(
                  "FAIL casc_hi t=%0t got=%0d exp=%0d",
                  $time, hi_bus.count, v / 10);
            end
        end
    end

    task automatic drive(
        input bit r, input bit e, input bit u,
        input bit l, input int d
    );
        @(posedge clk);
        #2;
        rst     = r;
        en      = e;
        up      = u;
        load    = l;
        din_raw = 16'(d);
    endtask

    initial begin
        rst = 1'b0;
        en  = 1'b1;
        up  = 1'b1;
        // reset held with en high, then count to 6
        repeat (3) drive(0, 1, 1, 0, 0);
        repeat (6) drive(1, 1, 1, 0, 0);
        // reset dropped between edges, released with en
        drive(0, 1, 1, 0, 0);
        repeat (3) drive(1, 1, 1, 0, 0);
        // load beats en; out-of-range load gives 0
        drive(1, 1, 1, 1, 7);
        drive(1, 1, 1, 1, 12);
        drive(1, 0, 1, 0, 0);
        // down wrap from 0 and back
        drive(1, 0, 1, 1, 0);
        repeat (10) drive(1, 1, 0, 0, 0);
        // up wrap run
        drive(1, 0, 1, 1, 0);
        repeat (7) drive(1, 1, 1, 0, 0);
        // direction flip at a boundary
        drive(1, 1, 0, 0, 0);
        drive(1, 1, 1, 0, 0);
        // top values, power-of-two and wide wraps
        drive(1, 0, 1, 1, 15);
        repeat (2) drive(1, 1, 1, 0, 0);
        drive(1, 0, 1, 1, 299);
        repeat (2) drive(1, 1, 1, 0, 0);
        drive(1, 1, 0, 1, 4);
        repeat (2) drive(1, 1, 1, 0, 0);
        // randomized traffic
        repeat (600) begin
            drive($urandom_range(0, 49) != 0,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) != 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 511));
        end
        @(posedge clk);
        #2;
        run = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
